// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debouncer.
// State encoding, glitch-counter width and saturation value.
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW   = 2'b00,
      ST_CHK_H = 2'b01,
      ST_HIGH  = 2'b10,
      ST_CHK_L = 2'b11
   } state_e;

   localparam int GLITCH_CNT_W = 8;

   localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

   function automatic logic [GLITCH_CNT_W-1:0] sat_inc(
      input logic [GLITCH_CNT_W-1:0] v
   );
      return (v == GLITCH_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_cell.sv
// Multi-flop synchronizer for a single asynchronous level.
// All stages reset asynchronously to 0.
module sync_cell #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic q_out
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_in};
      end
   end

   assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizer plus stability-qualifying FSM for a raw level input.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic data_in,
   output logic data_out,
`ifdef DEBOUNCE_GLITCH_CNT_EN
   output logic busy,
   output logic [GLITCH_CNT_W-1:0] glitch_cnt
`else
   output logic busy
`endif
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);

   logic             sync_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             out_q, out_d;
   logic             busy_q, busy_d;
   logic             abort;

   sync_cell #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (data_in),
      .q_out (sync_q)
   );

   assign cnt_inc = cnt_q + CNT_ONE;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      abort   = 1'b0;
      unique case (state_q)
         ST_LOW: begin
            if (sync_q) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = ST_HIGH;
                  out_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_CHK_H;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ST_CHK_H: begin
            if (sync_q) begin
               if (cnt_inc == CNT_LAST) begin
                  state_d = ST_HIGH;
                  out_d   = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else begin
               state_d = ST_LOW;
               cnt_d   = '0;
               abort   = 1'b1;
            end
         end
         ST_HIGH: begin
            if (!sync_q) begin
               if (STABLE_CYCLES == 1) begin
                  state_d = ST_LOW;
                  out_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_CHK_L;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ST_CHK_L: begin
            if (!sync_q) begin
               if (cnt_inc == CNT_LAST) begin
                  state_d = ST_LOW;
                  out_d   = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               abort   = 1'b1;
            end
         end
      endcase
      busy_d = (state_d == ST_CHK_H) || (state_d == ST_CHK_L);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   assign data_out = out_q;
   assign busy     = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [GLITCH_CNT_W-1:0] glitch_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_q <= '0;
      end else if (abort) begin
         glitch_q <= sat_inc(glitch_q);
      end
   end

   assign glitch_cnt = glitch_q;
`else
   // Abort strobe has no consumer without the glitch counter.
   logic unused_abort;
   assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default instance plus a
// SYNC_STAGES=3 / STABLE_CYCLES=1 instance, scoreboard-checked.
module tb_input_debouncer;

   logic clk = 1'b0;
   logic rst_n;
   logic data_in;
   logic data_out;
   logic busy;
   logic data_in2;
   logic data_out2;
   logic busy2;
`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_cnt;
   logic [7:0] glitch_cnt2;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit busy2_seen = 1'b0;

   string      exp_tag[$];
   logic [7:0] exp_val[$];

   always #5 clk = ~clk;

   input_debouncer u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_out   (data_out),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .busy       (busy),
      .glitch_cnt (glitch_cnt)
`else
      .busy       (busy)
`endif
   );

   input_debouncer #(
      .SYNC_STAGES   (3),
      .STABLE_CYCLES (1)
   ) u_dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in2),
      .data_out   (data_out2),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .busy       (busy2),
      .glitch_cnt (glitch_cnt2)
`else
      .busy       (busy2)
`endif
   );

   always @(negedge clk) begin
      if (busy2 === 1'b1) busy2_seen = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [7:0] v);
      exp_tag.push_back(tag);
      exp_val.push_back(v);
   endtask

   task automatic check(input logic [7:0] obs);
      string      tag;
      logic [7:0] exp;
      if (exp_tag.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
         return;
      end
      tag = exp_tag.pop_front();
      exp = exp_val.pop_front();
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      push(tag, {7'd0, exp});
      check({7'd0, obs});
   endtask

   initial begin
      rst_n    = 1'b0;
      data_in  = 1'b0;
      data_in2 = 1'b0;
      #1;
      chk("rst_out", data_out, 1'b0);
      chk("rst_busy", busy, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      push("rst_glitch", 8'h00);
      check(glitch_cnt);
`endif
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // second instance: 3 sync stages, single-sample acceptance
      data_in2 = 1'b1;
      tick(3);
      chk("i2_rise_e3", data_out2, 1'b0);
      tick(1);
      chk("i2_rise_e4", data_out2, 1'b1);
      data_in2 = 1'b0;
      tick(3);
      chk("i2_fall_e3", data_out2, 1'b1);
      tick(1);
      chk("i2_fall_e4", data_out2, 1'b0);

      // clean rise, 18-edge latency
      data_in = 1'b1;
      tick(2);
      chk("rise_e2_busy", busy, 1'b0);
      tick(1);
      chk("rise_e3_busy", busy, 1'b1);
      chk("rise_e3_out", data_out, 1'b0);
      tick(14);
      chk("rise_e17_busy", busy, 1'b1);
      chk("rise_e17_out", data_out, 1'b0);
      tick(1);
      chk("rise_e18_out", data_out, 1'b1);
      chk("rise_e18_busy", busy, 1'b0);

      // clean fall
      data_in = 1'b0;
      tick(17);
      chk("fall_e17_out", data_out, 1'b1);
      tick(1);
      chk("fall_e18_out", data_out, 1'b0);

      data_in = 1'b1;
      tick(20);
      chk("rerise_out", data_out, 1'b1);

      // fall with a one-cycle high glitch mid-qualification
      data_in = 1'b0;
      tick(10);
      chk("gfall_busy", busy, 1'b1);
      data_in = 1'b1;
      tick(1);
      data_in = 1'b0;
      tick(2);
      chk("gfall_abort_busy", busy, 1'b0);
      chk("gfall_abort_out", data_out, 1'b1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      push("gfall_glitch", 8'h01);
      check(glitch_cnt);
`endif
      tick(15);
      chk("gfall_e17_out", data_out, 1'b1);
      tick(1);
      chk("gfall_e18_out", data_out, 1'b0);

      // async reset while output high
      data_in = 1'b1;
      tick(20);
      chk("pre_rst_out", data_out, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out", data_out, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      push("async_rst_glitch", 8'h00);
      check(glitch_cnt);
`endif
      #1;
      rst_n = 1'b1;
      tick(17);
      chk("post_rst_e17", data_out, 1'b0);
      tick(1);
      chk("post_rst_e18", data_out, 1'b1);

      // reset mid-qualification leaves no partial count
      data_in = 1'b0;
      tick(20);
      chk("low_again", data_out, 1'b0);
      data_in = 1'b1;
      tick(10);
      chk("midq_busy", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midq_rst_busy", busy, 1'b0);
      #1;
      rst_n = 1'b1;
      tick(17);
      chk("midq_e17", data_out, 1'b0);
      tick(1);
      chk("midq_e18", data_out, 1'b1);
      data_in = 1'b0;
      tick(20);
      chk("midq_low", data_out, 1'b0);

      // bounce: 10 cycles high then back low
      data_in = 1'b1;
      tick(10);
      chk("bounce_busy", busy, 1'b1);
      data_in = 1'b0;
      tick(3);
      chk("bounce_busy_drop", busy, 1'b0);
      chk("bounce_out", data_out, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      push("bounce_glitch", 8'h01);
      check(glitch_cnt);
`endif
      tick(20);
      chk("bounce_out_late", data_out, 1'b0);

      // many aborted bounces
      for (int i = 0; i < 300; i++) begin
         data_in = 1'b1;
         tick(4);
         data_in = 1'b0;
         tick(4);
      end
      tick(5);
      chk("sat_out", data_out, 1'b0);
      chk("sat_busy", busy, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      push("sat_glitch", 8'hFF);
      check(glitch_cnt);
`endif
      for (int i = 0; i < 5; i++) begin
         data_in = 1'b1;
         tick(4);
         data_in = 1'b0;
         tick(4);
      end
      tick(5);
      chk("sat_hold_out", data_out, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      push("sat_hold_glitch", 8'hFF);
      check(glitch_cnt);
`endif

      chk("i2_busy_never", busy2_seen, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
